// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pool sequencer: state encoding,
// default widths and map-geometry helper functions.
package pool_pkg;

  localparam int unsigned DEF_N  = 3;
  localparam int unsigned DEF_DW = 16;
  localparam int unsigned DEF_AW = 8;

  localparam int unsigned ST_W = 3;

  // Sequencer state enumeration
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
  localparam logic [ST_W-1:0] ST_SETUP = 3'd2;
  localparam logic [ST_W-1:0] ST_POOL  = 3'd3;
  localparam logic [ST_W-1:0] ST_FIN   = 3'd4;

  // Input map side for a pooled side of n
  function automatic int unsigned map_size(input int unsigned n);
    return 2 * n;
  endfunction

  function automatic int unsigned load_beats(input int unsigned n);
    return 4 * n * n;
  endfunction

  function automatic int unsigned out_beats(input int unsigned n);
    return n * n;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_seq_cnt.sv
// Up-counter with synchronous clear, count enable and terminal-count flag.
module pool_seq_cnt #(
  parameter int unsigned W    = 4,
  parameter int unsigned LAST = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc_c
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc_c = (cnt == W'(LAST));

endmodule

// File: rtl/pool_seq.sv
// Frame sequencer for the 2x2 max-pool engine: loads a 2N x 2N map, then
// streams N x N pooled results to the output buffer. Optional cycle counter
// under POOL_SEQ_CYCLE_CNT_EN.
module pool_seq
  import pool_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic          conv_valid,
  input  logic [DW-1:0] conv_data,
  output logic          conv_ready,
  output logic          ld_en,
  output logic [DW-1:0] ld_data,
  output logic          pool_en,
  input  logic [DW-1:0] pool_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done
`ifdef POOL_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]   cycle_cnt
`endif
);

  localparam int unsigned LD_BEATS = load_beats(N);
  localparam int unsigned OUT_N    = out_beats(N);
  localparam int unsigned LD_W     = cnt_w(LD_BEATS);
  localparam int unsigned OUT_W    = cnt_w(OUT_N);

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_nxt;
  logic             beat_c;
  logic             ld_clr_c;
  logic             ld_tc_c;
  logic             out_clr_c;
  logic             out_en_c;
  logic             out_tc_c;
  logic [LD_W-1:0]  unused_ld_cnt;
  logic [OUT_W-1:0] out_cnt;

  logic             conv_ready_nxt;
  logic             pool_en_nxt;
  logic             wr_en_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [AW-1:0]    wr_addr_nxt;

  // Load handshake and engine/buffer data paths are pure passthroughs
  assign beat_c  = conv_valid & conv_ready;
  assign ld_en   = beat_c;
  assign ld_data = conv_data;
  assign wr_data = pool_data;

  assign ld_clr_c  = (state != ST_LOAD) | abort;
  assign out_clr_c = (state != ST_POOL) | abort;
  assign out_en_c  = (state == ST_POOL);

  // The load count only feeds its terminal flag
  pool_seq_cnt #(
    .W    (LD_W),
    .LAST (LD_BEATS - 1)
  ) u_ld_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ld_clr_c),
    .en      (beat_c),
    .cnt     (unused_ld_cnt),
    .tc_c    (ld_tc_c)
  );

  pool_seq_cnt #(
    .W    (OUT_W),
    .LAST (OUT_N - 1)
  ) u_out_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (out_clr_c),
    .en      (out_en_c),
    .cnt     (out_cnt),
    .tc_c    (out_tc_c)
  );

  // Next state and next registered outputs; abort overrides everything
  always_comb begin
    state_nxt      = state;
    conv_ready_nxt = 1'b0;
    pool_en_nxt    = 1'b0;
    wr_en_nxt      = 1'b0;
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;
    wr_addr_nxt    = AW'(BASE_ADDR);

    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_LOAD;
        ST_LOAD:  if (beat_c && ld_tc_c) state_nxt = ST_SETUP;
        ST_SETUP: state_nxt = ST_POOL;
        ST_POOL:  if (out_tc_c) state_nxt = ST_FIN;
        ST_FIN:   state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end

    conv_ready_nxt = (state_nxt == ST_LOAD);
    pool_en_nxt    = (state_nxt == ST_SETUP) || (state_nxt == ST_POOL);
    wr_en_nxt      = (state_nxt == ST_POOL);
    busy_nxt       = (state_nxt != ST_IDLE);
    done_nxt       = (state_nxt == ST_FIN);

    // Address for the coming write: BASE_ADDR + out_cnt of that cycle
    if (state_nxt == ST_POOL) begin
      wr_addr_nxt = AW'(BASE_ADDR) + AW'(out_cnt)
                  + ((state == ST_POOL) ? AW'(1) : AW'(0));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      conv_ready <= 1'b0;
      pool_en    <= 1'b0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_addr    <= AW'(BASE_ADDR);
    end else begin
      state      <= state_nxt;
      conv_ready <= conv_ready_nxt;
      pool_en    <= pool_en_nxt;
      wr_en      <= wr_en_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      wr_addr    <= wr_addr_nxt;
    end
  end

`ifdef POOL_SEQ_CYCLE_CNT_EN
  // Frame cycle counter: cleared by an accepted start, saturating, frozen by abort
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= 32'd0;
    end else if (abort) begin
      cycle_cnt <= cycle_cnt;
    end else if ((state == ST_IDLE) && start) begin
      cycle_cnt <= 32'd0;
    end else if ((state != ST_IDLE) && (cycle_cnt != 32'hFFFF_FFFF)) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pool_seq.sv
// Scoreboard bench for pool_seq: two instances (base 0 and base 250) share
// stimulus; a stand-in engine supplies max-pooled values.
`timescale 1ns/1ps
module tb_pool_seq;

  localparam int N     = 3;
  localparam int SZ    = 2 * N;
  localparam int LB    = SZ * SZ;
  localparam int OB    = N * N;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int BASE1 = 250;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n, start, abort, conv_valid;
  logic [DW-1:0] conv_data, pool_data;

  logic          conv_ready0, ld_en0, pool_en0, wr_en0, busy0, done0;
  logic          conv_ready1, ld_en1, pool_en1, wr_en1, busy1, done1;
  logic [DW-1:0] ld_data0, wr_data0, ld_data1, wr_data1;
  logic [AW-1:0] wr_addr0, wr_addr1;
`ifdef POOL_SEQ_CYCLE_CNT_EN
  logic [31:0]   cyc0, cyc1;
`endif

  int errors = 0;
  int checks = 0;
  int exp_done = 0;
  int done_seen0 = 0;
  int done_seen1 = 0;

  logic [DW-1:0] exp_ld0[$];
  logic [DW-1:0] exp_ld1[$];
  wr_t           exp_wr0[$];
  wr_t           exp_wr1[$];

  always #5 clk = ~clk;

  pool_seq #(.N(N), .DW(DW), .AW(AW), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .conv_valid(conv_valid), .conv_data(conv_data), .conv_ready(conv_ready0),
    .ld_en(ld_en0), .ld_data(ld_data0), .pool_en(pool_en0), .pool_data(pool_data),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0), .done(done0)
`ifdef POOL_SEQ_CYCLE_CNT_EN
    , .cycle_cnt(cyc0)
`endif
  );

  pool_seq #(.N(N), .DW(DW), .AW(AW), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .conv_valid(conv_valid), .conv_data(conv_data), .conv_ready(conv_ready1),
    .ld_en(ld_en1), .ld_data(ld_data1), .pool_en(pool_en1), .pool_data(pool_data),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .busy(busy1), .done(done1)
`ifdef POOL_SEQ_CYCLE_CNT_EN
    , .cycle_cnt(cyc1)
`endif
  );

  function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c, input logic [DW-1:0] e);
    logic [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (e > m) m = e;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stand-in pooling engine: captures loaded samples, then after one
  // initialisation cycle of pool_en presents one 2x2 max per cycle.
  logic [DW-1:0] eng_map [LB];
  int eng_idx, pcnt, p, b;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_idx <= 0;
      pcnt    <= 0;
    end else begin
      if (!busy0) eng_idx <= 0;
      else if (ld_en0 && eng_idx < LB) begin
        eng_map[eng_idx] <= ld_data0;
        eng_idx <= eng_idx + 1;
      end
      pcnt <= pool_en0 ? pcnt + 1 : 0;
    end
  end

  always_comb begin
    p = (pcnt == 0) ? 0 : ((pcnt > OB) ? OB - 1 : pcnt - 1);
    b = (p / N) * 2 * SZ + (p % N) * 2;
    pool_data = (pcnt == 0) ? '0 : max4(eng_map[b], eng_map[b+1], eng_map[b+SZ], eng_map[b+SZ+1]);
  end

  // Monitor: pop and compare whenever a DUT presents a load or a write
  always @(negedge clk) begin
    if (reset_n) begin
      if (ld_en0) begin
        checks++;
        if (exp_ld0.size() == 0) begin
          errors++; $display("FAIL ld0_unexpected: got ld_en with data %0h, required none", ld_data0);
        end else begin
          logic [DW-1:0] e; e = exp_ld0.pop_front();
          if (ld_data0 !== e) begin errors++; $display("FAIL ld0_data: got %0h expected %0h", ld_data0, e); end
        end
      end
      if (ld_en1) begin
        checks++;
        if (exp_ld1.size() == 0) begin
          errors++; $display("FAIL ld1_unexpected: got ld_en with data %0h, required none", ld_data1);
        end else begin
          logic [DW-1:0] e; e = exp_ld1.pop_front();
          if (ld_data1 !== e) begin errors++; $display("FAIL ld1_data: got %0h expected %0h", ld_data1, e); end
        end
      end
      if (wr_en0) begin
        checks++;
        if (exp_wr0.size() == 0) begin
          errors++; $display("FAIL wr0_unexpected: got write addr %0h data %0h, required none", wr_addr0, wr_data0);
        end else begin
          wr_t w; w = exp_wr0.pop_front();
          if (wr_addr0 !== w.addr || wr_data0 !== w.data) begin
            errors++;
            $display("FAIL wr0: got addr %0h data %0h expected addr %0h data %0h", wr_addr0, wr_data0, w.addr, w.data);
          end
        end
      end
      if (wr_en1) begin
        checks++;
        if (exp_wr1.size() == 0) begin
          errors++; $display("FAIL wr1_unexpected: got write addr %0h data %0h, required none", wr_addr1, wr_data1);
        end else begin
          wr_t w; w = exp_wr1.pop_front();
          if (wr_addr1 !== w.addr || wr_data1 !== w.data) begin
            errors++;
            $display("FAIL wr1: got addr %0h data %0h expected addr %0h data %0h", wr_addr1, wr_data1, w.addr, w.data);
          end
        end
      end
      if (done0) done_seen0++;
      if (done1) done_seen1++;
    end
  end

  // One frame. vmode: 0 valid held high with data 0..35, 1 toggling, 2 random.
  task automatic run_frame(input int vmode, input int abort_at, input bit poke_start);
    logic [DW-1:0] d [LB];
    logic          v;
    logic [DW-1:0] x;
    int            beats, cyc, nw, bb;
    wr_t           w;

    start = 1'b1; conv_valid = 1'b1; conv_data = 16'hdead;
    @(negedge clk);
    chk("idle_ready", conv_ready0, 0);
    chk("idle_ld_en", ld_en0, 0);
    chk("idle_busy", busy0, 0);
    step();
    start = 1'b0;

    beats = 0; cyc = 0;
    while (beats < LB && cyc < 2000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      x = (vmode == 0) ? DW'(beats) : DW'($urandom);
      conv_valid = v; conv_data = x;
      start = poke_start && (cyc == 3);
      if (v) begin
        d[beats] = x;
        exp_ld0.push_back(x);
        exp_ld1.push_back(x);
      end
      @(negedge clk);
      chk("load_ready", conv_ready0, 1);
      chk("load_ld_en", ld_en0, 32'(v));
      chk("load_busy", busy0, 1);
      chk("load_pool_en", pool_en0, 0);
      if (v) beats++;
      step();
      cyc++;
    end
    if (beats < LB) chk("load_beats_timeout", 32'(beats), 32'(LB));

    // Valid kept high after the last beat must be ignored
    start = 1'b0; conv_valid = 1'b1; conv_data = 16'hbeef;
    @(negedge clk);
    chk("setup_ready", conv_ready0, 0);
    chk("setup_ld_en", ld_en0, 0);
    chk("setup_pool_en", pool_en0, 1);
    chk("setup_wr_en", wr_en0, 0);
    chk("setup_busy", busy0, 1);

    nw = (abort_at > 0) ? abort_at : OB;
    for (int k = 0; k < nw; k++) begin
      bb = (k / N) * 2 * SZ + (k % N) * 2;
      w.data = max4(d[bb], d[bb+1], d[bb+SZ], d[bb+SZ+1]);
      w.addr = AW'(k);
      exp_wr0.push_back(w);
      w.addr = AW'(BASE1 + k);
      exp_wr1.push_back(w);
    end
    step();
    conv_valid = 1'b0;

    for (int k = 0; k < nw; k++) begin
      abort = (abort_at > 0) && (k == nw - 1);
      @(negedge clk);
      chk("pool_wr_en0", wr_en0, 1);
      chk("pool_wr_en1", wr_en1, 1);
      chk("pool_done", done0, 0);
      step();
      abort = 1'b0;
    end

    if (abort_at > 0) begin
      @(negedge clk);
      chk("abort_busy", busy0, 0);
      chk("abort_wr_en", wr_en0, 0);
      chk("abort_pool_en", pool_en0, 0);
      chk("abort_done", done0, 0);
      chk("abort_addr0", wr_addr0, 0);
      chk("abort_addr1", wr_addr1, BASE1);
    end else begin
      @(negedge clk);
      chk("fin_done0", done0, 1);
      chk("fin_done1", done1, 1);
      chk("fin_wr_en", wr_en0, 0);
      chk("fin_pool_en", pool_en0, 0);
      chk("fin_busy", busy0, 1);
      exp_done++;
      step();
      @(negedge clk);
      chk("post_busy", busy0, 0);
      chk("post_done", done0, 0);
      chk("post_addr1", wr_addr1, BASE1);
`ifdef POOL_SEQ_CYCLE_CNT_EN
      if (vmode == 0) chk("cycle_cnt", cyc0, 47);
`endif
    end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; conv_valid = 1'b0; conv_data = '0;
    #12;
    chk("rst_ready", conv_ready0, 0);
    chk("rst_ld_en", ld_en0, 0);
    chk("rst_pool_en", pool_en0, 0);
    chk("rst_wr_en", wr_en0, 0);
    chk("rst_addr0", wr_addr0, 0);
    chk("rst_addr1", wr_addr1, BASE1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    step();
    reset_n = 1'b1;
    step();

    run_frame(0, 0, 1'b0);
    run_frame(1, 0, 1'b0);
    run_frame(0, 4, 1'b0);
    run_frame(2, 0, 1'b0);
    run_frame(2, 0, 1'b1);

    // start together with abort in IDLE stays IDLE
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", busy0, 0);
    chk("start_abort_ready", conv_ready0, 0);
    step();

    // Asynchronous reset in the middle of a load
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      conv_valid = 1'b1; conv_data = DW'(100 + i);
      exp_ld0.push_back(DW'(100 + i));
      exp_ld1.push_back(DW'(100 + i));
      step();
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_ready", conv_ready0, 0);
    chk("mid_rst_ld_en", ld_en0, 0);
    chk("mid_rst_addr1", wr_addr1, BASE1);
`ifdef POOL_SEQ_CYCLE_CNT_EN
    chk("mid_rst_cycle_cnt", cyc0, 0);
`endif
    conv_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    run_frame(2, 0, 1'b0);

    chk("done_cnt0", 32'(done_seen0), 32'(exp_done));
    chk("done_cnt1", 32'(done_seen1), 32'(exp_done));
    chk("ld_q_left", 32'(exp_ld0.size() + exp_ld1.size()), 0);
    chk("wr_q_left", 32'(exp_wr0.size() + exp_wr1.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
